// File: rtl/calc_alu_sequencer.sv
// Multi-cycle controller for the calculator's shared 4-bit adder: sequences
// ADD, SUB (two's complement, signed 8-bit result) and MUL (shift-add) over one start/done handshake.
module calc_alu_sequencer #(
  parameter int MUL_STEPS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] result,
  output logic [3:0] add_a,
  output logic [3:0] add_b,
  input  logic [7:0] add_sum
);

  localparam int CNT_W = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ADD,
    S_SUB1,
    S_SUB2,
    S_MUL,
    S_ILL
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [1:0]       r_op;
  logic [3:0]       r_a;
  logic [3:0]       r_b;
  logic [4:0]       r_n;
  logic [3:0]       r_hi;
  logic [3:0]       r_lo;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic             r_err;
  logic [7:0]       r_result;

  logic       w_mul_last;
  logic       w_sub_nb;
  logic [7:0] w_sub_result;
  logic       w_unused;

  // The adder zero-extends its sum, so bits above the carry carry no information.
  assign w_unused = ^add_sum[7:5];

  assign w_mul_last   = (r_cnt == CNT_W'(MUL_STEPS - 1));
  // A carry out of either pass means A >= B, i.e. the difference is non-negative.
  assign w_sub_nb     = add_sum[4] | r_n[4];
  assign w_sub_result = w_sub_nb ? {4'h0, add_sum[3:0]} : {4'hF, add_sum[3:0]};

  assign busy   = (r_state != S_IDLE);
  assign done   = r_done;
  assign err    = r_err;
  assign result = r_result;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
    w_next_state = r_state;
    add_a        = 4'd0;
    add_b        = 4'd0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next_state = (op == OP_ILL) ? S_ILL : S_SETUP;
      end
      S_SETUP: begin
        case (r_op)
          OP_ADD:  w_next_state = S_ADD;
          OP_SUB:  w_next_state = S_SUB1;
          OP_MUL:  w_next_state = S_MUL;
          default: w_next_state = S_ILL;
        endcase
      end
      S_ADD: begin
        add_a        = r_a;
        add_b        = r_b;
        w_next_state = S_IDLE;
      end
      S_SUB1: begin
        add_a        = ~r_b;
        add_b        = 4'd1;
        w_next_state = S_SUB2;
      end
      S_SUB2: begin
        add_a        = r_a;
        add_b        = r_n[3:0];
        w_next_state = S_IDLE;
      end
      S_MUL: begin
        add_a = r_hi;
        add_b = r_lo[0] ? r_a : 4'd0;
        if (w_mul_last) w_next_state = S_IDLE;
      end
      S_ILL:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (rst) begin
      r_state  <= S_IDLE;
      r_op     <= OP_ADD;
      r_a      <= 4'd0;
      r_b      <= 4'd0;
      r_n      <= 5'd0;
      r_hi     <= 4'd0;
      r_lo     <= 4'd0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_result <= 8'h00;
    end else begin
      r_state <= w_next_state;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op <= op;
            r_a  <= a;
            r_b  <= b;
          end
        end
        S_SETUP: begin
          r_hi  <= 4'd0;
          r_lo  <= r_b;
          r_cnt <= '0;
        end
        S_ADD: begin
          r_result <= {3'b000, add_sum[4:0]};
          r_done   <= 1'b1;
          r_err    <= 1'b0;
        end
        S_SUB1: r_n <= add_sum[4:0];
        S_SUB2: begin
          r_result <= w_sub_result;
          r_done   <= 1'b1;
          r_err    <= 1'b0;
        end
        S_MUL: begin
          // Partial product shifts right one place per step; LSB of HI falls into LO.
          r_hi  <= add_sum[4:1];
          r_lo  <= {add_sum[0], r_lo[3:1]};
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_mul_last) begin
            r_result <= {add_sum[4:0], r_lo[3:1]};
            r_done   <= 1'b1;
            r_err    <= 1'b0;
          end
        end
        S_ILL: begin
          r_result <= 8'h00;
          r_done   <= 1'b1;
          r_err    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
